// File: rtl/cam_param_masked.sv
// Masked-search CAM: DEPTH entries of DATA_W bits with per-entry valid bits.
// Registered search returns highest matching index plus hit/multi-hit; tracks occupancy.
module cam_param_masked #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              wen,
  input  logic              inv,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] mask,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] dout,
  output logic              hit,
  output logic              multi_hit,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] dout_q, srch_idx;
  logic              hit_q, multi_q, srch_hit, srch_multi;
  logic [DEPTH-1:0]  match;

  // Ascending scan so the last match seen is the highest index.
  always_comb begin
    match      = '0;
    srch_hit   = 1'b0;
    srch_multi = 1'b0;
    srch_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match[i] = valid_q[i] && (((mem_q[i] ^ din) & ~mask) == '0);
      if (match[i]) begin
        if (srch_hit) srch_multi = 1'b1;
        srch_hit = 1'b1;
        srch_idx = ADDR_W'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (ren) begin
      // search has priority; wen/inv are dropped
    end else if (wen) begin
      if (!valid_q[addr]) count_d = count_q + CntOne;
      valid_d[addr] = 1'b1;
    end else if (inv) begin
      if (valid_q[addr]) count_d = count_q - CntOne;
      valid_d[addr] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      dout_q  <= '0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      dout_q  <= ren ? srch_idx : '0;
      hit_q   <= ren & srch_hit;
      multi_q <= ren & srch_multi;
    end
  end

  // Entry payload is not reset; valid bits alone gate matching.
  always_ff @(posedge clk) begin
    if (wen && !ren) mem_q[addr] <= din;
  end

  assign dout      = dout_q;
  assign hit       = hit_q;
  assign multi_hit = multi_q;
  assign count     = count_q;
  assign full      = (count_q == CntFull);

endmodule

// File: tb/tb_cam_param_masked.sv
// Directed plus randomized bench for cam_param_masked against an array-based reference model.
module tb_cam_param_masked;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ren, wen, inv;
  logic [DATA_W-1:0] din, mask;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] dout;
  logic              hit, multi_hit, full;
  logic [ADDR_W:0]   count;

  cam_param_masked #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .inv(inv), .din(din), .mask(mask),
    .addr(addr), .dout(dout), .hit(hit), .multi_hit(multi_hit), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: plain arrays, results recomputed from scratch each search.
  logic [DATA_W-1:0] m_data  [DEPTH];
  bit                m_valid [DEPTH];
  int                e_dout;
  bit                e_hit, e_multi;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_valid[i] ? 1 : 0;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dout"},  32'(dout),      32'(e_dout));
    chk({tag, "_hit"},   32'(hit),       32'(e_hit));
    chk({tag, "_multi"}, 32'(multi_hit), 32'(e_multi));
    chk({tag, "_count"}, 32'(count),     32'(m_count()));
    chk({tag, "_full"},  32'(full),      32'(m_count() == DEPTH));
  endtask

  // One clock cycle of stimulus; inputs applied away from the edge, checked #1 after it.
  task automatic cycle(input bit r, input bit w, input bit iv, input logic [7:0] d,
                       input logic [7:0] m, input logic [3:0] a, input string tag);
    int nmatch = 0;
    ren = r; wen = w; inv = iv; din = d; mask = m; addr = a;
    e_dout = 0; e_hit = 0; e_multi = 0;
    if (r) begin
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i] && ((m_data[i] & ~m) == (d & ~m))) begin
          nmatch++;
          e_dout = i;
        end
      e_hit = nmatch > 0;
      e_multi = nmatch > 1;
    end else if (w) begin
      m_data[a] = d;
      m_valid[a] = 1;
    end else if (iv) begin
      m_valid[a] = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    e_dout = 0; e_hit = 0; e_multi = 0;
  endtask

  initial begin
    ren = 0; wen = 0; inv = 0; din = '0; mask = '0; addr = '0;
    for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
    model_reset();
    rst = 1;
    #12;
    check_all("reset");
    rst = 0;
    @(posedge clk); #1;

    // 1: empty CAM never matches
    cycle(1, 0, 0, 8'h00, 8'h00, 4'd0, "t1_search");
    chk("t1_hit_lit", 32'(hit), 0);

    // 2: single entry hit
    cycle(0, 1, 0, 8'hA5, 8'h00, 4'd3, "t2_wr");
    cycle(1, 0, 0, 8'hA5, 8'h00, 4'd0, "t2_search");
    chk("t2_dout_lit", 32'(dout), 3);
    chk("t2_count_lit", 32'(count), 1);
    cycle(0, 0, 0, 8'hA5, 8'h00, 4'd0, "t2_idle");

    // 3: multi-hit reports highest index, then invalidate it
    cycle(0, 1, 0, 8'h3C, 8'h00, 4'd2, "t3_wr2");
    cycle(0, 1, 0, 8'h3C, 8'h00, 4'd9, "t3_wr9");
    cycle(1, 0, 0, 8'h3C, 8'h00, 4'd0, "t3_search");
    chk("t3_dout_lit", 32'(dout), 9);
    chk("t3_multi_lit", 32'(multi_hit), 1);
    cycle(0, 0, 1, 8'h00, 8'h00, 4'd9, "t3_inv9");
    cycle(1, 0, 0, 8'h3C, 8'h00, 4'd0, "t3_search2");
    chk("t3_dout2_lit", 32'(dout), 2);

    // 4: masked compare
    cycle(0, 1, 0, 8'hF0, 8'h00, 4'd5, "t4_wr");
    cycle(1, 0, 0, 8'hFF, 8'h0F, 4'd0, "t4_masked");
    chk("t4_dout_lit", 32'(dout), 5);
    cycle(1, 0, 0, 8'hFF, 8'h00, 4'd0, "t4_unmasked");
    chk("t4_hit_lit", 32'(hit), 0);

    // 5: fill, overwrite when full, double invalidate
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(i * 7), 8'h00, 4'(i), "t5_fill");
    chk("t5_full_lit", 32'(full), 1);
    chk("t5_count_lit", 32'(count), 16);
    cycle(0, 1, 0, 8'h55, 8'h00, 4'd0, "t5_rewrite");
    cycle(0, 0, 1, 8'h00, 8'h00, 4'd0, "t5_inv_a");
    chk("t5_inv_a_lit", 32'(count), 15);
    cycle(0, 0, 1, 8'h00, 8'h00, 4'd0, "t5_inv_b");
    chk("t5_inv_b_lit", 32'(count), 15);

    // 6: ren+wen: write dropped, search sees old contents
    cycle(1, 1, 0, 8'h07, 8'h00, 4'd1, "t6_ren_wen");
    chk("t6_hit_lit", 32'(hit), 1);
    cycle(1, 0, 0, 8'h07, 8'h00, 4'd0, "t6_recheck");
    cycle(1, 0, 1, 8'h07, 8'h00, 4'd1, "t6_ren_inv");
    cycle(0, 1, 1, 8'hEE, 8'h00, 4'd4, "t6_wen_inv");
    cycle(1, 0, 0, 8'hEE, 8'h00, 4'd0, "t6_wen_won");

    // Randomized phase with a small key space so hits and multi-hits are common
    for (int n = 0; n < 400; n++) begin
      int op = $urandom_range(0, 9);
      logic [7:0] k = 8'({$urandom_range(0, 3), 2'b01});
      logic [7:0] m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cycle(op < 4, (op >= 3 && op < 7) || op == 9, op >= 6, k, m, 4'($urandom), "rand");
    end

    // Async reset mid-sequence: outputs clear immediately
    cycle(0, 1, 0, 8'h11, 8'h00, 4'd6, "t7_wr");
    cycle(1, 0, 0, 8'h11, 8'h00, 4'd0, "t7_search");
    ren = 1; din = 8'h11;
    #2 rst = 1;
    #1;
    model_reset();
    check_all("t7_async_rst");
    chk("t7_count_lit", 32'(count), 0);
    #1 rst = 0;
    cycle(1, 0, 0, 8'h11, 8'h00, 4'd0, "t7_after");
    chk("t7_after_hit_lit", 32'(hit), 0);
    cycle(1, 0, 0, 8'h00, 8'hFF, 4'd0, "t7_all_dc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
